// File: rtl/edge_pulse_gen_pkg.sv
// Shared definitions for the edge pulse generator: FSM state encoding and default timing constants.
package edge_pulse_gen_pkg;

  typedef enum logic [1:0] {
    EPG_STABLE  = 2'd0,
    EPG_QUALIFY = 2'd1,
    EPG_HOLDOFF = 2'd2
  } epg_state_e;

  localparam int unsigned EPG_DEB_COUNT_DEF = 4095;
  localparam int unsigned EPG_HOLDOFF_DEF   = 1024;

endpackage

// File: rtl/edge_pulse_gen_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous board input; async active-low reset to 0.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic CK,
  input  logic RSTb,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge CK or negedge RSTb) begin
    if (!RSTb) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/edge_pulse_gen.sv
// Debounces a slow asynchronous level into a clean LEVEL plus single-cycle RISE/FALL pulses,
// with a holdoff window after every accepted edge.
module edge_pulse_gen
  import edge_pulse_gen_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 13,
  parameter int unsigned DEB_COUNT   = EPG_DEB_COUNT_DEF,
  parameter int unsigned HOLDOFF     = EPG_HOLDOFF_DEF
) (
  input  logic CK,
  input  logic RSTb,
  input  logic IN,
  input  logic ENABLE,
  output logic LEVEL,
  output logic RISE_PULSE,
  output logic FALL_PULSE,
  output logic BUSY
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_COUNT - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF);
  localparam bit               DEB_ONE   = (DEB_COUNT == 1);
  localparam bit               HOLD_NONE = (HOLDOFF == 0);

  logic s;

  epg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic             accept;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .CK   (CK),
    .RSTb (RSTb),
    .d_i  (IN),
    .q_o  (s)
  );

  always_ff @(posedge CK or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= EPG_STABLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    accept  = 1'b0;

    unique case (state_q)
      EPG_STABLE: begin
        if (ENABLE && (s != level_q)) begin
          if (DEB_ONE) begin
            accept = 1'b1;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = EPG_QUALIFY;
          end
        end
      end
      EPG_QUALIFY: begin
        if (!ENABLE || (s == level_q)) begin
          cnt_d   = '0;
          state_d = EPG_STABLE;
        end else if (cnt_q >= DEB_LAST) begin
          accept = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EPG_HOLDOFF: begin
        // Input is ignored here; ENABLE does not stop the countdown.
        cnt_d = '0;
        if (hold_q <= CNT_W'(1)) begin
          hold_d  = '0;
          state_d = EPG_STABLE;
        end else begin
          hold_d = hold_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        hold_d  = '0;
        state_d = EPG_STABLE;
      end
    endcase

    if (accept) begin
      level_d = s;
      rise_d  = s;
      fall_d  = ~s;
      cnt_d   = '0;
      if (HOLD_NONE) begin
        state_d = EPG_STABLE;
      end else begin
        hold_d  = HOLD_LOAD;
        state_d = EPG_HOLDOFF;
      end
    end

    busy_d = (state_d != EPG_STABLE);
  end

  assign LEVEL      = level_q;
  assign RISE_PULSE = rise_q;
  assign FALL_PULSE = fall_q;
  assign BUSY       = busy_q;

endmodule
